// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead add/subtract unit with valid/ready handshake.
// Each stage resolves one WIDTH/STAGES-bit slice, LSB slice first, and carries the rest forward.
module pipe_cla_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NS = STAGES;
    localparam int SL = WIDTH / STAGES;
    localparam int NG = SL / BLOCK;

    // Returns carries c[0..SL] for one slice; c[0] = ci, c[SL] = slice carry-out.
    function automatic logic [SL:0] cla_carries(input logic [SL-1:0] g, input logic [SL-1:0] p,
                                                 input logic ci);
        logic [NG-1:0] gg;
        logic [NG-1:0] pg;
        logic [NG:0]   gc;
        logic [SL:0]   c;
        logic          term;
        for (int m = 0; m < NG; m++) begin
            gg[m] = 1'b0;
            pg[m] = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                gg[m] = g[m*BLOCK+i] | (p[m*BLOCK+i] & gg[m]);
                pg[m] = pg[m] & p[m*BLOCK+i];
            end
        end
        // Group carries as flattened sum-of-products, no group-to-group ripple.
        for (int m = 0; m <= NG; m++) begin
            term = ci;
            for (int l = 0; l < m; l++) term = term & pg[l];
            gc[m] = term;
            for (int j = 0; j < m; j++) begin
                term = gg[j];
                for (int l = j + 1; l < m; l++) term = term & pg[l];
                gc[m] = gc[m] | term;
            end
        end
        for (int m = 0; m < NG; m++) begin
            for (int i = 0; i < BLOCK; i++) begin
                term = gc[m];
                for (int l = 0; l < i; l++) term = term & p[m*BLOCK+l];
                c[m*BLOCK+i] = term;
                for (int j = 0; j < i; j++) begin
                    term = g[m*BLOCK+j];
                    for (int l = j + 1; l < i; l++) term = term & p[m*BLOCK+l];
                    c[m*BLOCK+i] = c[m*BLOCK+i] | term;
                end
            end
        end
        c[SL] = gc[NG];
        return c;
    endfunction

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [STAGES-1:0] c_q, c_d, v_q, v_in, adv;
    logic ovf_q, ovf_d, zero_q, neg_q;

    // Stage k may load when it is empty or its contents move on this cycle.
    always_comb begin
        adv = '0;
        adv[NS-1] = !v_q[NS-1] || out_ready;
        for (int k = NS - 2; k >= 0; k--) adv[k] = !v_q[k] || adv[k+1];
    end

    always_comb begin
        logic [SL-1:0]    g, p;
        logic [SL:0]      cv;
        logic [WIDTH-1:0] sa, sb, ss;
        logic             sc;
        int               km1;
        g = '0; p = '0; cv = '0; sa = '0; sb = '0; ss = '0; sc = 1'b0; km1 = 0;
        ovf_d = 1'b0;
        v_in  = '0;
        for (int k = 0; k < NS; k++) begin
            km1 = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                sa = a;
                sb = op ? ~b : b;
                sc = cin ^ op;
                ss = '0;
                v_in[k] = in_valid;
            end else begin
                sa = a_q[km1];
                sb = b_q[km1];
                sc = c_q[km1];
                ss = s_q[km1];
                v_in[k] = v_q[km1];
            end
            g  = sa[k*SL +: SL] & sb[k*SL +: SL];
            p  = sa[k*SL +: SL] ^ sb[k*SL +: SL];
            cv = cla_carries(g, p, sc);
            ss[k*SL +: SL] = p ^ cv[SL-1:0];
            a_d[k] = sa;
            b_d[k] = sb;
            s_d[k] = ss;
            c_d[k] = cv[SL];
            if (k == NS - 1) ovf_d = cv[SL] ^ cv[SL-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            for (int k = 0; k < NS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (adv[k]) begin
                    v_q[k] <= v_in[k];
                    if (v_in[k]) begin
                        a_q[k] <= a_d[k];
                        b_q[k] <= b_d[k];
                        s_q[k] <= s_d[k];
                        c_q[k] <= c_d[k];
                    end
                end
            end
            if (adv[NS-1] && v_in[NS-1]) begin
                ovf_q  <= ovf_d;
                zero_q <= (s_d[NS-1] == '0);
                neg_q  <= s_d[NS-1][WIDTH-1];
            end
        end
    end

    assign in_ready  = adv[0] & ~rst;
    assign out_valid = v_q[NS-1];
    assign s         = s_q[NS-1];
    assign cout      = c_q[NS-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Bench for pipe_cla_adder: directed corner cases and handshake checks on a 32/4/2 instance,
// then random traffic with backpressure on 32/4/2, 64/8/4 and 32/4/1 against an arithmetic model.
module tb_pipe_cla_adder;

    typedef struct packed {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0] a, b;
    logic        cin, op, out_ready;
    logic [2:0]  iv;
    logic        rdy0, rdy1, rdy2, vl0, vl1, vl2;
    logic [31:0] s0, s2;
    logic [63:0] s1;
    logic        co0, co1, co2, ov0, ov1, ov2, ze0, ze1, ze2, ng0, ng1, ng2;
    logic [2:0]  rdy, ovl;
    assign rdy = {rdy2, rdy1, rdy0};
    assign ovl = {vl2, vl1, vl0};

    pipe_cla_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy0), .a(a[31:0]), .b(b[31:0]),
        .cin(cin), .op(op), .out_valid(vl0), .out_ready(out_ready), .s(s0), .cout(co0),
        .ovf(ov0), .zero(ze0), .neg(ng0));
    pipe_cla_adder #(.WIDTH(64), .BLOCK(8), .STAGES(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy1), .a(a), .b(b),
        .cin(cin), .op(op), .out_valid(vl1), .out_ready(out_ready), .s(s1), .cout(co1),
        .ovf(ov1), .zero(ze1), .neg(ng1));
    pipe_cla_adder #(.WIDTH(32), .BLOCK(4), .STAGES(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy2), .a(a[31:0]), .b(b[31:0]),
        .cin(cin), .op(op), .out_valid(vl2), .out_ready(out_ready), .s(s2), .cout(co2),
        .ovf(ov2), .zero(ze2), .neg(ng2));

    int   total = 0;
    int   bad = 0;
    int   emitted = 0;
    res_t q[$];
    int   wd[3] = '{32, 64, 32};

    function automatic res_t observe(input int d);
        res_t r;
        case (d)
            0:       r = '{s: {32'h0, s0}, cout: co0, ovf: ov0, zero: ze0, neg: ng0};
            1:       r = '{s: s1, cout: co1, ovf: ov1, zero: ze1, neg: ng1};
            default: r = '{s: {32'h0, s2}, cout: co2, ovf: ov2, zero: ze2, neg: ng2};
        endcase
        return r;
    endfunction

    // Reference: plain w-bit arithmetic; overflow from operand/result signs.
    function automatic res_t model(input logic [63:0] ta, input logic [63:0] tb, input logic tc,
                                   input logic to, input int w);
        logic [63:0] mask, am, bm;
        logic [64:0] full;
        res_t        r;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am     = ta & mask;
        bm     = (to ? ~tb : tb) & mask;
        full   = {1'b0, am} + {1'b0, bm} + 65'(tc ^ to);
        r.s    = full[63:0] & mask;
        r.cout = full[w];
        r.neg  = r.s[w-1];
        r.zero = (r.s == 64'd0);
        r.ovf  = (am[w-1] == bm[w-1]) && (r.s[w-1] != am[w-1]);
        return r;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return '1;
            2:       return 64'h0000_0000_FFFF_FFFF;
            3:       return 64'h8000_0000_8000_0000;
            4:       return 64'h7FFF_FFFF_7FFF_FFFF;
            5:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, score accepts and emits.
    task automatic tick(input int d, input logic v, input logic [63:0] ta, input logic [63:0] tb,
                        input logic tc, input logic to, input logic ordy, output logic acc,
                        output logic rdy_seen, output logic vld_seen, output res_t seen);
        res_t e;
        iv = '0;
        iv[d] = v;
        a = ta; b = tb; cin = tc; op = to; out_ready = ordy;
        #1;
        rdy_seen = rdy[d];
        vld_seen = ovl[d];
        seen     = observe(d);
        acc      = v && rdy_seen;
        if (acc) q.push_back(model(ta, tb, tc, to, wd[d]));
        if (vld_seen && ordy) begin
            emitted++;
            chk("emit_expected", 68'(q.size() != 0), 68'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("result", seen, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic dir_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tc, input logic to, input res_t e);
        iv = 3'b001; a = {32'h0, ta}; b = {32'h0, tb}; cin = tc; op = to; out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, 68'(rdy0), 68'd1);
        @(negedge clk);
        iv = '0;
        #1 chk({tag, "_early"}, 68'(vl0), 68'd0);
        @(negedge clk);
        #1 chk({tag, "_valid"}, 68'(vl0), 68'd1);
        chk(tag, observe(0), e);
        @(negedge clk);
    endtask

    task automatic rand_run(input int d, input int n);
        logic        pend, acc, r, vl;
        res_t        sn;
        logic [63:0] ta, tb;
        logic        tc, to;
        int          sent, budget;
        pend = 1'b0; sent = 0; budget = n * 4 + 100; emitted = 0; q.delete();
        ta = '0; tb = '0; tc = 1'b0; to = 1'b0;
        while ((sent < n || q.size() != 0) && budget > 0) begin
            if (!pend && sent < n && $urandom_range(0, 4) != 0) begin
                ta = pick(); tb = pick();
                tc = 1'($urandom_range(0, 1)); to = 1'($urandom_range(0, 1));
                pend = 1'b1;
            end
            tick(d, pend, ta, tb, tc, to, $urandom_range(0, 3) != 0, acc, r, vl, sn);
            if (acc) begin
                pend = 1'b0;
                sent++;
            end
            budget--;
        end
        chk("rand_emitted", 68'(emitted), 68'(n));
    endtask

    initial begin
        logic        acc, r, vl;
        res_t        sn, held;
        logic [63:0] opa [4];
        logic [63:0] opb [4];
        int          nxt;

        // Reset with unknown inputs.
        rst = 1'b1; iv = 'x; a = 'x; b = 'x; cin = 'x; op = 'x; out_ready = 'x;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_outputs", observe(d), 68'd0);
            chk("rst_out_valid", 68'(ovl[d]), 68'd0);
            chk("rst_in_ready", 68'(rdy[d]), 68'd0);
        end
        repeat (2) @(negedge clk);
        iv = '0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b1; rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("release_in_ready", 68'(rdy[d]), 68'd1);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            tick(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, r, vl, sn);
            chk("idle_out_valid", 68'(vl), 68'd0);
        end

        // Directed corner cases, latency 2 on the 32/4/2 instance.
        dir_op("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
               '{s: 64'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1, neg: 1'b0});
        dir_op("sub_minneg", 32'h8000_0000, 32'h1, 1'b0, 1'b1,
               '{s: 64'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0, neg: 1'b0});
        dir_op("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1,
               '{s: 64'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b1});
        dir_op("add_maxpos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
               '{s: 64'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0, neg: 1'b1});
        dir_op("sub_borrow_in", 32'd10, 32'd3, 1'b1, 1'b1,
               '{s: 64'd6, cout: 1'b1, ovf: 1'b0, zero: 1'b0, neg: 1'b0});
        dir_op("add_cin", 32'd1, 32'd2, 1'b1, 1'b0,
               '{s: 64'd4, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0});

        // Back-to-back: 8 ops, results on consecutive cycles starting at cycle 2.
        emitted = 0; q.delete();
        for (int c = 0; c < 10; c++) begin
            tick(0, c < 8, {32'h0, $urandom}, {32'h0, $urandom}, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1, acc, r, vl, sn);
            chk("b2b_out_valid", 68'(vl), 68'(c >= 2));
            if (c < 8) chk("b2b_in_ready", 68'(r), 68'd1);
        end
        chk("b2b_count", 68'(emitted), 68'd8);

        // Backpressure after one result: two held, in_ready low, output stable, then drain.
        emitted = 0; q.delete(); nxt = 0;
        for (int i = 0; i < 4; i++) begin
            opa[i] = {32'h0, $urandom};
            opb[i] = {32'h0, $urandom};
        end
        held = '0;
        for (int c = 0; c < 12; c++) begin
            tick(0, nxt < 4, opa[nxt < 4 ? nxt : 0], opb[nxt < 4 ? nxt : 0], 1'b0, 1'(c % 2),
                 !(c >= 3 && c < 7), acc, r, vl, sn);
            if (acc) nxt++;
            if (c >= 3 && c < 7) begin
                chk("bp_in_ready", 68'(r), 68'd0);
                chk("bp_out_valid", 68'(vl), 68'd1);
            end
            if (c == 3) held = sn;
            if (c > 3 && c < 7) chk("bp_hold", sn, held);
        end
        chk("bp_count", 68'(emitted), 68'd4);
        chk("bp_empty", 68'(q.size()), 68'd0);

        // Reset with two operations in flight.
        q.delete();
        tick(0, 1'b1, 64'd11, 64'd22, 1'b0, 1'b0, 1'b0, acc, r, vl, sn);
        tick(0, 1'b1, 64'd33, 64'd44, 1'b0, 1'b0, 1'b0, acc, r, vl, sn);
        #1 chk("mid_pre_valid", 68'(vl0), 68'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 68'(vl0), 68'd0);
        chk("mid_rst_outputs", observe(0), 68'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, r, vl, sn);
            chk("mid_no_stale", 68'(vl), 68'd0);
        end

        // Random regressions with backpressure.
        rand_run(0, 3000);
        rand_run(1, 10000);
        rand_run(2, 10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
